// File: rtl/mem_responder.sv
// mem_responder: single-port word memory behind a CPU load/store handshake.
//
// A request is accepted in IDLE, spends Latency cycles in WAIT, and the
// access (read or read-modify-write) commits on the WAIT-to-RESP edge. RESP
// presents a one-cycle response strobe with the extended load data or an
// error flag for misaligned / illegal-size accesses.
//
// Ports:
//   clk           sole clock, rising-edge active
//   rst           asynchronous reset, active-low
//   req_valid     CPU request present
//   req_ready     responder can accept a request (IDLE only)
//   req_we        1 = store, 0 = load
//   req_size      00 byte, 01 half, 10 word, 11 illegal
//   req_unsigned  load extension: 1 = zero-extend, 0 = sign-extend
//   req_addr      byte address, little-endian
//   req_wdata     store data, right-aligned
//   resp_valid    one-cycle response strobe
//   resp_rdata    extended load data (0 for stores and errors)
//   resp_err      misaligned or illegal-size access
module mem_responder #(
  parameter int Depth   = 256,
  parameter int Latency = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int AW = $clog2(Depth);
  localparam int CW = (Latency > 1) ? $clog2(Latency) : 1;
  localparam logic [CW-1:0] CntInit = CW'(Latency - 1);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;
  typedef enum logic [1:0] {SZ_BYTE, SZ_HALF, SZ_WORD, SZ_BAD} size_e;

  state_e          state;
  logic [CW-1:0]   cnt;

  // Latched request; only the address bits that select a word and lane are kept.
  logic            we_q;
  size_e           size_q;
  logic            unsigned_q;
  logic [AW+1:0]   addr_q;
  logic [31:0]     wdata_q;

  logic [31:0]     mem [Depth];

  logic [AW-1:0]   idx;
  logic [1:0]      lane;
  logic [31:0]     rd_word;
  logic [31:0]     load_val;
  logic [31:0]     wr_mask;
  logic [31:0]     wr_data;
  logic [31:0]     wr_word;
  logic [7:0]      byte_val;
  logic [15:0]     half_val;
  logic            misaligned;
  logic            access_now;

  // Upper address bits wrap around and are deliberately dropped.
  logic unused_addr_bits;
  assign unused_addr_bits = ^req_addr[31:AW+2];

  assign idx        = addr_q[AW+1:2];
  assign lane       = addr_q[1:0];
  assign rd_word    = mem[idx];
  assign access_now = (state == WAIT) && (cnt == '0);

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    misaligned = 1'b0;
    load_val   = '0;
    wr_mask    = '0;
    wr_data    = '0;
    byte_val   = 8'(rd_word >> {lane, 3'b000});
    half_val   = lane[1] ? rd_word[31:16] : rd_word[15:0];
    unique case (size_q)
      SZ_BYTE: begin
        load_val = unsigned_q ? {24'h0, byte_val} : {{24{byte_val[7]}}, byte_val};
        wr_mask  = 32'h0000_00ff << {lane, 3'b000};
        wr_data  = {4{wdata_q[7:0]}};
      end
      SZ_HALF: begin
        misaligned = lane[0];
        load_val   = unsigned_q ? {16'h0, half_val} : {{16{half_val[15]}}, half_val};
        wr_mask    = lane[1] ? 32'hffff_0000 : 32'h0000_ffff;
        wr_data    = {2{wdata_q[15:0]}};
      end
      SZ_WORD: begin
        misaligned = (lane != 2'b00);
        load_val   = rd_word;
        wr_mask    = 32'hffff_ffff;
        wr_data    = wdata_q;
      end
      default: misaligned = 1'b1;
    endcase
    // Read-modify-write keeps the bytes outside the addressed lanes intact.
    wr_word = (rd_word & ~wr_mask) | (wr_data & wr_mask);
  end

  always_ff @(posedge clk or negedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (!rst) begin
      state      <= IDLE;
      cnt        <= '0;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      resp_rdata <= '0;
      we_q       <= 1'b0;
      size_q     <= SZ_BYTE;
      unsigned_q <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (req_valid) begin
            we_q       <= req_we;
            size_q     <= size_e'(req_size);
            unsigned_q <= req_unsigned;
            addr_q     <= req_addr[AW+1:0];
            wdata_q    <= req_wdata;
            cnt        <= CntInit;
            req_ready  <= 1'b0;
            state      <= WAIT;
          end
        end
        WAIT: begin
          if (cnt == '0) begin
            state      <= RESP;
            resp_valid <= 1'b1;
            resp_err   <= misaligned;
            resp_rdata <= (misaligned || we_q) ? 32'h0 : load_val;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        RESP: begin
          state      <= IDLE;
          req_ready  <= 1'b1;
          resp_valid <= 1'b0;
          resp_err   <= 1'b0;
          resp_rdata <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // The write commits only on the WAIT-to-RESP edge, so a reset during WAIT
  // aborts the store cleanly.
  always_ff @(posedge clk) begin
    // NOTE: the memory array has no reset; its contents survive rst by design.
    if (access_now && we_q && !misaligned) begin
      mem[idx] <= wr_word;
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: directed self-checking bench for mem_responder
// (Depth=256, Latency=2). Expected values are hand-computed constants.
module tb_mem_responder;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;

  int total = 0;
  int bad   = 0;

  localparam logic [1:0] SZB = 2'b00;
  localparam logic [1:0] SZH = 2'b01;
  localparam logic [1:0] SZW = 2'b10;
  localparam logic [1:0] SZX = 2'b11;

  mem_responder #(.Depth(256), .Latency(2)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .resp_valid   (resp_valid),
    .resp_rdata   (resp_rdata),
    .resp_err     (resp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Issues one request and waits (bounded) for its response. edges is the
  // number of rising edges after the accept edge up to the edge that first
  // samples resp_valid=1, or -1 on timeout.
  task automatic do_access(input logic we, input logic [1:0] size, input logic uns,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           output logic [31:0] rdata, output logic err, output int edges);
    int n;
    int guard;
    logic seen;
    @(negedge clk);
    guard = 0;
    while (!req_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    req_valid    = 1'b1;
    req_we       = we;
    req_size     = size;
    req_unsigned = uns;
    req_addr     = addr;
    req_wdata    = wdata;
    @(posedge clk);
    #1 req_valid = 1'b0;
    n     = 0;
    seen  = 1'b0;
    rdata = 32'h0;
    err   = 1'b0;
    while (!seen && n < 20) begin
      @(posedge clk);
      n++;
      #1;
      if (resp_valid === 1'b1) begin
        seen  = 1'b1;
        rdata = resp_rdata;
        err   = resp_err;
      end
    end
    edges = seen ? n + 1 : -1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req_valid = 1'b0; req_we = 1'b0; req_size = SZW; req_unsigned = 1'b0;
    req_addr = 32'h0; req_wdata = 32'h0;
    #1 rst = 1'b0;
    #1;
    total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b want=1", req_ready); end
    total++; if (resp_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", resp_valid); end
    total++; if (resp_err !== 1'b0) begin bad++; $display("FAIL reset_err got=%b want=0", resp_err); end
    total++; if (resp_rdata !== 32'h0) begin bad++; $display("FAIL reset_rdata got=%h want=0", resp_rdata); end
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_basic();
    logic [31:0] rd; logic er; int ed;
    do_access(1'b1, SZW, 1'b0, 32'h10, 32'h8899AABB, rd, er, ed);
    total++; if (ed !== 3) begin bad++; $display("FAIL store_latency got=%0d want=3", ed); end
    total++; if (rd !== 32'h0) begin bad++; $display("FAIL store_rdata got=%h want=0", rd); end
    total++; if (er !== 1'b0) begin bad++; $display("FAIL store_err got=%b want=0", er); end
    // One-cycle strobe, then idle outputs all zero.
    @(posedge clk); #1;
    total++; if (resp_valid !== 1'b0) begin bad++; $display("FAIL strobe_len got=%b want=0", resp_valid); end
    total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL ready_after got=%b want=1", req_ready); end
    do_access(1'b0, SZW, 1'b0, 32'h10, 32'h0, rd, er, ed);
    total++; if (ed !== 3) begin bad++; $display("FAIL load_latency got=%0d want=3", ed); end
    total++; if (rd !== 32'h8899AABB) begin bad++; $display("FAIL load_word got=%h want=8899aabb", rd); end
    total++; if (er !== 1'b0) begin bad++; $display("FAIL load_err got=%b want=0", er); end
    @(posedge clk); #1;
    total++; if (resp_rdata !== 32'h0) begin bad++; $display("FAIL idle_rdata got=%h want=0", resp_rdata); end
  endtask

  task automatic test_subword_load();
    logic [31:0] rd; logic er; int ed;
    do_access(1'b0, SZB, 1'b0, 32'h11, 32'h0, rd, er, ed);
    total++; if (rd !== 32'hFFFFFFAA) begin bad++; $display("FAIL lb_signed got=%h want=ffffffaa", rd); end
    do_access(1'b0, SZB, 1'b1, 32'h11, 32'h0, rd, er, ed);
    total++; if (rd !== 32'h000000AA) begin bad++; $display("FAIL lb_unsigned got=%h want=000000aa", rd); end
    do_access(1'b0, SZH, 1'b0, 32'h12, 32'h0, rd, er, ed);
    total++; if (rd !== 32'hFFFF8899) begin bad++; $display("FAIL lh_signed got=%h want=ffff8899", rd); end
    do_access(1'b0, SZH, 1'b1, 32'h10, 32'h0, rd, er, ed);
    total++; if (rd !== 32'h0000AABB) begin bad++; $display("FAIL lh_unsigned got=%h want=0000aabb", rd); end
    do_access(1'b0, SZB, 1'b0, 32'h10, 32'h0, rd, er, ed);
    total++; if (rd !== 32'hFFFFFFBB) begin bad++; $display("FAIL lb_lane0 got=%h want=ffffffbb", rd); end
    do_access(1'b0, SZB, 1'b1, 32'h12, 32'h0, rd, er, ed);
    total++; if (rd !== 32'h00000099) begin bad++; $display("FAIL lb_lane2 got=%h want=00000099", rd); end
    do_access(1'b0, SZW, 1'b1, 32'h10, 32'h0, rd, er, ed);
    total++; if (rd !== 32'h8899AABB) begin bad++; $display("FAIL lw_unsigned got=%h want=8899aabb", rd); end
  endtask

  task automatic test_subword_store();
    logic [31:0] rd; logic er; int ed;
    do_access(1'b1, SZB, 1'b0, 32'h13, 32'hFFFFFF5A, rd, er, ed);
    total++; if (er !== 1'b0) begin bad++; $display("FAIL sb_err got=%b want=0", er); end
    do_access(1'b0, SZW, 1'b0, 32'h10, 32'h0, rd, er, ed);
    total++; if (rd !== 32'h5A99AABB) begin bad++; $display("FAIL sb_merge got=%h want=5a99aabb", rd); end
    do_access(1'b1, SZH, 1'b0, 32'h10, 32'hABCD1234, rd, er, ed);
    do_access(1'b0, SZW, 1'b0, 32'h10, 32'h0, rd, er, ed);
    total++; if (rd !== 32'h5A991234) begin bad++; $display("FAIL sh_merge got=%h want=5a991234", rd); end
  endtask

  task automatic test_misaligned();
    logic [31:0] rd; logic er; int ed;
    do_access(1'b1, SZH, 1'b0, 32'h11, 32'h0000FFFF, rd, er, ed);
    total++; if (er !== 1'b1) begin bad++; $display("FAIL sh_mis_err got=%b want=1", er); end
    total++; if (ed !== 3) begin bad++; $display("FAIL mis_latency got=%0d want=3", ed); end
    do_access(1'b0, SZW, 1'b0, 32'h10, 32'h0, rd, er, ed);
    total++; if (rd !== 32'h5A991234) begin bad++; $display("FAIL mis_no_write got=%h want=5a991234", rd); end
    do_access(1'b0, SZW, 1'b0, 32'h12, 32'h0, rd, er, ed);
    total++; if (er !== 1'b1) begin bad++; $display("FAIL lw_mis_err got=%b want=1", er); end
    total++; if (rd !== 32'h0) begin bad++; $display("FAIL lw_mis_rdata got=%h want=0", rd); end
    do_access(1'b0, SZX, 1'b0, 32'h10, 32'h0, rd, er, ed);
    total++; if (er !== 1'b1) begin bad++; $display("FAIL size11_err got=%b want=1", er); end
    total++; if (rd !== 32'h0) begin bad++; $display("FAIL size11_rdata got=%h want=0", rd); end
    do_access(1'b1, SZX, 1'b0, 32'h10, 32'h00000000, rd, er, ed);
    do_access(1'b0, SZW, 1'b0, 32'h10, 32'h0, rd, er, ed);
    total++; if (rd !== 32'h5A991234) begin bad++; $display("FAIL size11_no_write got=%h want=5a991234", rd); end
  endtask

  task automatic test_reset_abort();
    logic [31:0] rd; logic er; int ed;
    do_access(1'b1, SZW, 1'b0, 32'h20, 32'h11223344, rd, er, ed);
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_size = SZW; req_unsigned = 1'b0;
    req_addr = 32'h20; req_wdata = 32'hDEADBEEF;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL abort_ready got=%b want=1", req_ready); end
    total++; if (resp_valid !== 1'b0) begin bad++; $display("FAIL abort_valid got=%b want=0", resp_valid); end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    do_access(1'b0, SZW, 1'b0, 32'h20, 32'h0, rd, er, ed);
    total++; if (rd !== 32'h11223344) begin bad++; $display("FAIL abort_old_data got=%h want=11223344", rd); end
  endtask

  task automatic test_wrap();
    logic [31:0] rd; logic er; int ed;
    do_access(1'b0, SZW, 1'b0, 32'h410, 32'h0, rd, er, ed);
    total++; if (rd !== 32'h5A991234) begin bad++; $display("FAIL wrap_load got=%h want=5a991234", rd); end
    do_access(1'b1, SZW, 1'b0, 32'hFFFF_F7FC, 32'h0BADF00D, rd, er, ed);
    do_access(1'b0, SZW, 1'b0, 32'h3FC, 32'h0, rd, er, ed);
    total++; if (rd !== 32'h0BADF00D) begin bad++; $display("FAIL wrap_store got=%h want=0badf00d", rd); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd; logic er; int ed;
    int n;
    logic seen;
    @(negedge clk);
    while (!req_ready) @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_size = SZW; req_unsigned = 1'b0;
    req_addr = 32'h10; req_wdata = 32'h0;
    @(posedge clk);
    // Valid stays high with a different request; it must wait for IDLE.
    #1 req_addr = 32'h20; req_we = 1'b1; req_wdata = 32'hCAFEF00D;
    n = 0; seen = 1'b0; rd = 32'h0;
    while (!seen && n < 20) begin
      @(posedge clk); n++; #1;
      if (resp_valid === 1'b1) begin seen = 1'b1; rd = resp_rdata; end
    end
    ed = seen ? n + 1 : -1;
    total++; if (ed !== 3) begin bad++; $display("FAIL hold_latency got=%0d want=3", ed); end
    total++; if (rd !== 32'h5A991234) begin bad++; $display("FAIL hold_latched got=%h want=5a991234", rd); end
    @(posedge clk); #1;
    total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL hold_no_early_accept got=%b want=1", req_ready); end
    @(posedge clk); #1;
    total++; if (req_ready !== 1'b0) begin bad++; $display("FAIL hold_accept_after_resp got=%b want=0", req_ready); end
    req_valid = 1'b0;
    n = 0; seen = 1'b0; er = 1'b1;
    while (!seen && n < 20) begin
      @(posedge clk); n++; #1;
      if (resp_valid === 1'b1) begin seen = 1'b1; er = resp_err; end
    end
    total++; if (seen !== 1'b1 || er !== 1'b0) begin bad++; $display("FAIL second_resp got seen=%b err=%b want seen=1 err=0", seen, er); end
    do_access(1'b0, SZW, 1'b0, 32'h20, 32'h0, rd, er, ed);
    total++; if (rd !== 32'hCAFEF00D) begin bad++; $display("FAIL second_store got=%h want=cafef00d", rd); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_subword_load();
    test_subword_store();
    test_misaligned();
    test_reset_abort();
    test_wrap();
    test_back_to_back();
    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
